alu_exec_stage: RTL and testbench

//  Execute/write-back stage beside the 4x8 main register file. Takes two operands read

---
 rtl/alu_exec_stage.sv | 202 ++++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Execute/write-back stage: single-cycle ALU ops plus an iterative shift-add multiplier,
// returning each result as a one-cycle write-back pulse to the register file.
module alu_exec_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_code,
  input  logic [ADDR_WIDTH-1:0] op_dest,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  wb_write,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  logic [1:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] dest_q,     dest_d;
  logic [PW-1:0]         mcand_q,    mcand_d;
  logic [W-1:0]          mplier_q,   mplier_d;
  logic [PW-1:0]         acc_q,      acc_d;
  logic [CW-1:0]         cnt_q,      cnt_d;
  logic                  wb_write_q, wb_write_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q,  wb_addr_d;
  logic [W-1:0]          wb_data_q,  wb_data_d;
  logic                  zero_q,     zero_d;
  logic                  carry_q,    carry_d;

  logic [W:0]            sum_ext;
  logic [W:0]            diff_ext;
  logic [W-1:0]          alu_data;
  logic                  alu_carry;
  logic [PW-1:0]         mul_sum;

  logic                  commit;
  logic                  commit_write;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [W-1:0]          commit_data;
  logic                  commit_carry;

  assign op_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign wb_write   = wb_write_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;

  // Single-cycle ops evaluate straight from the presented operands at the accept edge.
  always_comb begin
    sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    diff_ext = {1'b0, op_a} - {1'b0, op_b};
    alu_data  = '0;
    alu_carry = 1'b0;
    case (op_code)
      OP_ADD: begin
        alu_data  = sum_ext[W-1:0];
        alu_carry = sum_ext[W];
      end
      OP_SUB, OP_CMP: begin
        alu_data  = diff_ext[W-1:0];
        alu_carry = diff_ext[W];
      end
      OP_AND: alu_data = op_a & op_b;
      OP_OR:  alu_data = op_a | op_b;
      OP_XOR: alu_data = op_a ^ op_b;
      OP_SHL: begin
        alu_data  = {op_a[W-2:0], 1'b0};
        alu_carry = op_a[W-1];
      end
      default: begin
        alu_data  = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    commit       = 1'b0;
    commit_write = 1'b0;
    commit_addr  = dest_q;
    commit_data  = '0;
    commit_carry = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          dest_d = op_dest;
          if (op_code == OP_MUL) begin
            mcand_d  = PW'(op_a);
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            commit       = 1'b1;
            commit_write = (op_code != OP_CMP);
            commit_addr  = op_dest;
            commit_data  = alu_data;
            commit_carry = alu_carry;
            state_d      = S_WB;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // The final iteration's sum is committed directly so WB follows the last step.
        if (cnt_q == LAST_ITER) begin
          commit       = 1'b1;
          commit_write = 1'b1;
          commit_data  = mul_sum[W-1:0];
          commit_carry = |mul_sum[PW-1:W];
          state_d      = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // CMP updates only the flags; address and data keep the last real write-back.
  always_comb begin
    wb_write_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    if (commit) begin
      wb_write_d = commit_write;
      zero_d     = (commit_data == '0);
      carry_d    = commit_carry;
      if (commit_write) begin
        wb_addr_d = commit_addr;
        wb_data_d = commit_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dest_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      wb_write_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wb_write_q <= wb_write_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: expectations pushed at accept, popped on write-back.
module tb_alu_exec_stage;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 2;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SHL = 3'b101;
  localparam logic [2:0] MUL = 3'b110;
  localparam logic [2:0] CMP = 3'b111;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [AW-1:0] op_dest;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          wb_write;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          flag_zero;
  logic          flag_carry;
  logic          busy;

  alu_exec_stage #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_dest   (op_dest),
    .op_a      (op_a),
    .op_b      (op_b),
    .wb_write  (wb_write),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flag_zero (flag_zero),
    .flag_carry(flag_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          zero;
    logic          carry;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wb  = 0;

  function automatic exp_t model(input logic [2:0] c, input logic [AW-1:0] d,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t            e;
    logic [2*W-1:0]  p;
    e.addr  = d;
    e.carry = 1'b0;
    e.data  = '0;
    case (c)
      ADD: {e.carry, e.data} = {1'b0, a} + {1'b0, b};
      SUB, CMP: begin
        e.data  = a - b;
        e.carry = (a < b);
      end
      AND: e.data = a & b;
      OR:  e.data = a | b;
      XOR: e.data = a ^ b;
      SHL: begin
        e.data  = a << 1;
        e.carry = a[W-1];
      end
      default: begin
        p       = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.data  = p[W-1:0];
        e.carry = (p[2*W-1:W] != '0);
      end
    endcase
    e.zero = (e.data == '0);
    return e;
  endfunction

  // Inputs change just after posedge, so at negedge they show what the next edge accepts.
  always @(negedge clk) begin
    if (reset === 1'b0 && op_valid === 1'b1 && op_ready === 1'b1 && op_code != CMP)
      sb.push_back(model(op_code, op_dest, op_a, op_b));
  end

  always @(negedge clk) begin
    exp_t e;
    if (wb_write === 1'b1) begin
      n_wb++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got addr=%0d data=%02h, required no write-back", wb_addr, wb_data);
      end else begin
        e = sb.pop_front();
        if (wb_addr !== e.addr || wb_data !== e.data || flag_zero !== e.zero || flag_carry !== e.carry) begin
          n_bad++;
          $display("FAIL wb_result: got addr=%0d data=%02h z=%b c=%b, required addr=%0d data=%02h z=%b c=%b",
                   wb_addr, wb_data, flag_zero, flag_carry, e.addr, e.data, e.zero, e.carry);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] c, input logic [AW-1:0] d,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    op_code = c; op_dest = d; op_a = a; op_b = b; op_valid = 1'b1;
    while (op_ready !== 1'b1 && guard < 30) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 30) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: op_ready=%b, required 1 within 30 cycles", op_ready);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(op_ready === 1'b1 && sb.size() == 0) && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: pending=%0d op_ready=%b, required 0 pending and ready", sb.size(), op_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; op_code = '0; op_dest = '0; op_a = '0; op_b = '0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({wb_write, wb_addr, wb_data, flag_zero, flag_carry, op_ready, busy} !== {1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got wr=%b addr=%0d data=%02h z=%b c=%b rdy=%b busy=%b, required 0 0 00 0 0 1 0",
               wb_write, wb_addr, wb_data, flag_zero, flag_carry, op_ready, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_add();
    drive(ADD, 2'd2, 8'hF0, 8'h20);
    @(negedge clk);
    n_cmp++;
    if ({wb_write, wb_addr, wb_data, flag_carry, flag_zero, busy} !== {1'b1, 2'd2, 8'h10, 1'b1, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL add_latency: got wr=%b addr=%0d data=%02h c=%b z=%b busy=%b, required 1 2 10 1 0 1",
               wb_write, wb_addr, wb_data, flag_carry, flag_zero, busy);
    end
    wait_idle();
  endtask

  task automatic test_sub_cmp();
    drive(SUB, 2'd3, 8'h05, 8'h05);
    @(negedge clk);
    n_cmp++;
    if ({wb_write, wb_data, flag_zero, flag_carry} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL sub_zero: got wr=%b data=%02h z=%b c=%b, required 1 00 1 0", wb_write, wb_data, flag_zero, flag_carry);
    end
    wait_idle();
    drive(CMP, 2'd0, 8'h03, 8'h04);
    @(negedge clk);
    n_cmp++;
    if ({wb_write, wb_addr, wb_data, flag_carry, flag_zero, busy} !== {1'b0, 2'd3, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL cmp_flags: got wr=%b addr=%0d data=%02h c=%b z=%b busy=%b, required 0 3 00 1 0 1",
               wb_write, wb_addr, wb_data, flag_carry, flag_zero, busy);
    end
    wait_idle();
    drive(CMP, 2'd1, 8'h77, 8'h77);
    @(negedge clk);
    n_cmp++;
    if ({wb_write, flag_zero, flag_carry} !== {1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL cmp_equal: got wr=%b z=%b c=%b, required 0 1 0", wb_write, flag_zero, flag_carry);
    end
    wait_idle();
  endtask

  task automatic test_mul();
    int          low_cnt = 0;
    int          wb_at   = 0;
    logic [W-1:0] cap_data  = '0;
    logic         cap_carry = 1'b0;
    drive(MUL, 2'd1, 8'h13, 8'h11);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (op_ready === 1'b0) low_cnt++;
      if (wb_write === 1'b1 && wb_at == 0) begin
        wb_at = i; cap_data = wb_data; cap_carry = flag_carry;
      end
    end
    n_cmp++;
    if (low_cnt != 9 || wb_at != 9) begin
      n_bad++;
      $display("FAIL mul_timing: got ready-low=%0d wb-cycle=%0d, required 9 and 9", low_cnt, wb_at);
    end
    n_cmp++;
    if (cap_data !== 8'h43 || cap_carry !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_13x11: got data=%02h c=%b, required 43 1", cap_data, cap_carry);
    end
    wait_idle();
    drive(MUL, 2'd0, 8'h0F, 8'h03);
    wait_idle();
    n_cmp++;
    if (wb_data !== 8'h2D || flag_carry !== 1'b0 || wb_addr !== 2'd0) begin
      n_bad++;
      $display("FAIL mul_0fx03: got addr=%0d data=%02h c=%b, required 0 2d 0", wb_addr, wb_data, flag_carry);
    end
  endtask

  task automatic test_alu_ops();
    for (int i = 0; i < 14; i++) begin
      drive(3'($urandom_range(0, 7)), AW'($urandom), W'($urandom), W'($urandom));
      wait_idle();
    end
    drive(MUL, 2'd2, 8'hFF, 8'hFF);
    wait_idle();
    drive(SHL, 2'd3, 8'h80, 8'h5A);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0]   codes [6] = '{ADD, SUB, XOR, SHL, AND, OR};
    logic [W-1:0] as    [6] = '{8'h7F, 8'h10, 8'hAA, 8'h81, 8'hF0, 8'h00};
    logic [W-1:0] bs    [6] = '{8'h01, 8'h20, 8'h55, 8'h33, 8'h3C, 8'h00};
    int k = 0, cyc = 0, last_acc = -1, guard = 0, wb_start;
    logic acc;
    wb_start = n_wb;
    op_code = codes[0]; op_dest = 2'd0; op_a = as[0]; op_b = bs[0]; op_valid = 1'b1;
    while (k < 6 && guard < 40) begin
      @(negedge clk);
      acc = op_ready;
      @(posedge clk); #1;
      cyc++; guard++;
      if (acc === 1'b1) begin
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc != 2) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d cycles between accepts, required 2", cyc - last_acc);
          end
        end
        last_acc = cyc;
        k++;
        if (k < 6) begin
          op_code = codes[k]; op_dest = AW'(k); op_a = as[k]; op_b = bs[k];
        end else begin
          op_valid = 1'b0;
        end
      end
    end
    op_valid = 1'b0;
    wait_idle();
    n_cmp++;
    if (n_wb - wb_start != 6) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d write-backs, required 6", n_wb - wb_start);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic saw = 1'b0;
    drive(ADD, 2'd0, 8'hFF, 8'h01);
    wait_idle();
    drive(MUL, 2'd3, 8'hFF, 8'hFF);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    repeat (15) begin
      @(negedge clk);
      if (wb_write !== 1'b0) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0 || {flag_zero, flag_carry, wb_data, op_ready, busy} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_mul: got wb-seen=%b z=%b c=%b data=%02h rdy=%b busy=%b, required 0 0 0 00 1 0",
               saw, flag_zero, flag_carry, wb_data, op_ready, busy);
    end
    @(posedge clk); #1;
    drive(ADD, 2'd1, 8'h01, 8'h02);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul();
    test_alu_ops();
    test_back_to_back();
    test_reset_mid_mul();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending results, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
